mem_dbus_ctrl: RTL
==================

MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

Interface
REQ-001 SHALL: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: mem_op_i  in  4  MEM-stage access op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-004 SHALL: addr_i  in  32  effective address; wdata_i  in  32  store source register value.
REQ-005 SHALL: stall_i  in  1  MEM stage held this cycle; flush_i  in  1  pipeline flush.
REQ-006 SHALL: data_req  out  1; data_wr  out  1; data_size  out  2 (0 byte, 1 half, 2 word); data_addr  out  32; data_wdata  out  32.
REQ-007 SHALL: data_addr_ok  in  1; data_data_ok  in  1; data_rdata  in  32  (SRAM-like bus, little-endian).
REQ-008 SHALL: rdata_o  out  32  extended load result; stall_req_o  out  1  MEM stage stall request.
REQ-009 SHALL: adel_o  out  1; ades_o  out  1; badvaddr_o  out  32  address-error outputs.

Function
REQ-010 SHALL: FSM states IDLE, WAIT_DATA, DONE, DRAIN; "valid" = mem_op_i in 1..8, "exc" = adel_o|ades_o.
REQ-011 SHALL: IDLE with valid & !exc & !flush_i -> data_req=1 combinationally; data_addr_ok=1 in same cycle -> WAIT_DATA.
REQ-012 SHALL: data_req=0 in every state other than IDLE; at most one outstanding transaction.
REQ-013 SHALL: WAIT_DATA on data_data_ok -> capture extended data into result register, go DONE; on flush_i without data_data_ok -> DRAIN.
REQ-014 SHALL: WAIT_DATA with flush_i and data_data_ok in same cycle -> IDLE, data discarded.
REQ-015 SHALL: DONE -> IDLE when stall_i=0 or flush_i=1; otherwise hold; no reissue while in DONE.
REQ-016 SHALL: DRAIN -> IDLE on data_data_ok, data discarded.
REQ-017 SHALL: stall_req_o=1 in IDLE (valid & !exc & !flush_i), WAIT_DATA, DRAIN; 0 in DONE and otherwise.
REQ-018 SHALL: data_wr=1 for ops 6-8; data_size 0 for LB/LBU/SB, 1 for LH/LHU/SH, 2 for LW/SW; data_addr=addr_i.
REQ-019 SHALL: data_wdata SB {4{wdata_i[7:0]}}, SH {2{wdata_i[15:0]}}, SW wdata_i.
REQ-020 SHALL: load extension selects byte addr_i[1:0] / halfword addr_i[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-021 SHALL: rdata_o = result register in DONE, 0 otherwise; stores leave result register unchanged.
REQ-022 SHALL: addr_i/mem_op_i stable while stall_req_o=1 (stage held); module samples addr_i[1:0] at data_data_ok.

Reset
REQ-023 SHALL: rst -> state IDLE, result register 0; next-cycle outputs data_req 0, stall_req_o 0, rdata_o 0.
REQ-024 SHALL: rst mid-transaction abandons it (state IDLE, no drain); bus side reset jointly.

Configuration
REQ-025 SHALL: macro DBUS_ADDR_EXC_EN defined -> LH/LHU with addr_i[0]!=0 or LW with addr_i[1:0]!=0 gives adel_o=1; same for SH/SW gives ades_o=1; badvaddr_o=addr_i; no request issued, stall_req_o=0.
REQ-026 SHALL: macro undefined -> adel_o=ades_o=0, badvaddr_o=0, misaligned accesses issued unchanged.

Verification
REQ-027 SHALL: LB addr 0x1003, rdata 0x80FF_FF00, addr_ok same cycle, data_ok 2 cycles later -> rdata_o 0xFFFF_FF80 in DONE, stall_req_o 1 for 3 cycles.
REQ-028 SHALL: SH addr 0x2002, wdata 0x1234_ABCD -> data_wr 1, size 1, data_wdata 0xABCD_ABCD, stall_req_o drops at DONE.
REQ-029 SHALL: LW completes while stall_i=1 for 3 cycles -> single data_req, DONE holds rdata_o, IDLE after stall_i falls.
REQ-030 SHALL: flush_i in WAIT_DATA, data_ok 4 cycles later with new LW presented -> DRAIN, no data_req until drained, then new LW issued.
REQ-031 SHALL: DBUS_ADDR_EXC_EN, LW addr 0x3002 -> adel_o 1, badvaddr_o 0x3002, data_req 0; SW addr 0x3001 -> ades_o 1.
REQ-032 SHALL: rst asserted in WAIT_DATA -> state IDLE next cycle, data_req 0, stall_req_o 0, rdata_o 0.

Source files
------------

// File: rtl/mem_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_dbus_ctrl
// Purpose  : MEM-stage data-bus controller. It turns a load/store op into a
//            single SRAM-like bus transaction, holds the pipeline until the
//            data phase completes, and sign/zero-extends load data.
//            At most one transaction is outstanding. A flush during the data
//            phase makes the controller drain the orphaned response before
//            it accepts new work.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            mem_op_i, addr_i, wdata_i - access op, effective address, store data
//            stall_i, flush_i         - MEM stage hold / pipeline flush
//            data_req/wr/size/addr/wdata - request channel to the bus
//            data_addr_ok/data_ok/rdata  - bus handshakes and read data
//            rdata_o, stall_req_o     - extended load result, stall request
//            adel_o, ades_o, badvaddr_o - address-error outputs
// Config   : `define DBUS_ADDR_EXC_EN raises alignment exceptions; without it
//            misaligned accesses go out on the bus unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dbus_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_o,
    output logic        stall_req_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_DONE      = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;

    logic        w_valid, w_is_load, w_is_store, w_exc;
    logic [31:0] w_load_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_valid    = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd8);
    assign w_is_load  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    assign w_is_store = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);

    // Request channel attributes are decoded straight from the op.
    always_comb begin
        data_size  = 2'd0;
        data_wdata = wdata_i;
        unique case (mem_op_i)
            4'd1, 4'd2: data_size = 2'd0;
            4'd3, 4'd4: data_size = 2'd1;
            4'd5:       data_size = 2'd2;
            4'd6: begin
                data_size  = 2'd0;
                data_wdata = {4{wdata_i[7:0]}};
            end
            4'd7: begin
                data_size  = 2'd1;
                data_wdata = {2{wdata_i[15:0]}};
            end
            4'd8:       data_size = 2'd2;
            default:    data_size = 2'd0;
        endcase
    end

    assign data_wr   = w_is_store;
    assign data_addr = addr_i;

`ifdef DBUS_ADDR_EXC_EN
    logic w_misalign;
    assign w_misalign = ((data_size == 2'd1) && addr_i[0]) ||
                        ((data_size == 2'd2) && (addr_i[1:0] != 2'b00));
    assign adel_o     = w_is_load  && w_misalign;
    assign ades_o     = w_is_store && w_misalign;
    assign badvaddr_o = (adel_o || ades_o) ? addr_i : 32'd0;
`else
    assign adel_o     = 1'b0;
    assign ades_o     = 1'b0;
    assign badvaddr_o = 32'd0;
`endif

    assign w_exc = adel_o || ades_o;

    // Little-endian lane select; addr_i is still valid here because the
    // stage is held until the data phase completes.
    always_comb begin
        unique case (addr_i[1:0])
            2'd0:    w_byte = data_rdata[7:0];
            2'd1:    w_byte = data_rdata[15:8];
            2'd2:    w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
        w_half = addr_i[1] ? data_rdata[31:16] : data_rdata[15:0];
        unique case (mem_op_i)
            4'd1:    w_load_ext = {{24{w_byte[7]}}, w_byte};
            4'd2:    w_load_ext = {24'd0, w_byte};
            4'd3:    w_load_ext = {{16{w_half[15]}}, w_half};
            4'd4:    w_load_ext = {16'd0, w_half};
            default: w_load_ext = data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        data_req    = 1'b0;
        stall_req_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (w_valid && !w_exc && !flush_i) begin
                    data_req    = 1'b1;
                    stall_req_o = 1'b1;
                    if (data_addr_ok) begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                stall_req_o = 1'b1;
                if (data_data_ok) begin
                    // A flush arriving with the data just discards it.
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (w_is_load) begin
                            result_d = w_load_ext;
                        end
                        state_d = ST_DONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                // Result is held for the stage; no reissue while stalled.
                if (!stall_i || flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                stall_req_o = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdata_o = (state_q == ST_DONE) ? result_q : 32'd0;

endmodule
`default_nettype wire
